rx_sample_packer: RTL and testbench
===================================

Name: rx_sample_packer

Overview:
- Upstream feeder for the RX write-DMA stage. Accepts a continuous 32-bit ADC sample stream (16-bit I + 16-bit Q), packs four samples into one 128-bit word, and buffers the words in an on-chip FIFO.
- Presents the FIFO as a 128-bit AXI-Stream master.
- Raises rx_fifo_data_ready once at least one full DMA burst of words is buffered.
- Samples that arrive when the FIFO cannot accept them are dropped and counted, because the ADC side cannot be stalled.

Parameters:
- DEPTH, 512, FIFO depth in 128-bit words; must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH)+1, width of fifo_level. Derived; not set by the user.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- enable  in  1  capture enable; when low, samples are ignored.
- flush  in  1  synchronous clear of the FIFO and the packer.
- s_adc_tdata  in  32  sample; I in [15:0], Q in [31:16].
- s_adc_tvalid  in  1  sample-valid strobe; there is no ready signal.
- burst_len  in  9  DMA burst length in words, range 1..256; 0 is treated as 1.
- m_axis_rx_tdata  out  128  FIFO head word.
- m_axis_rx_tvalid  out  1  FIFO not empty.
- m_axis_rx_tready  in  1  consumer ready.
- rx_fifo_data_ready  out  1  fifo_level >= burst_len.
- fifo_level  out  LVL_W  number of words currently stored.
- overflow_ins  out  1  one-cycle pulse for each dropped word.
- overflow_count  out  16  number of dropped words; saturates.

Behaviour:
- Reset (areset=1, asynchronous):
  - Pointers, level, packer lane, overflow_ins and overflow_count are all 0.
  - m_axis_rx_tvalid and rx_fifo_data_ready are 0.
  - m_axis_rx_tdata is 0.
  - Outputs take these values immediately, without waiting for a clock edge.
- Packer:
  - A 2-bit lane counter advances on each cycle where enable && s_adc_tvalid.
  - The sample accepted in lane k lands in word bits [32k+31:32k]; the first sample goes to the LSBs.
  - When the lane-3 sample is accepted, the completed word is offered for push on that same clock edge.
- Push, pop and level:
  - pop = m_axis_rx_tvalid && m_axis_rx_tready.
  - A push is accepted when fifo_level < DEPTH, or when pop is true in the same cycle.
  - If the push is accepted, the word is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - If the push is not accepted, the word is discarded, overflow_ins=1 for one cycle, and overflow_count increments, saturating at 16'hFFFF.
  - The packer keeps running after a drop; lane alignment is never lost.
  - fifo_level <= fifo_level + push_accepted - pop. It is registered, so a change is visible the cycle after the edge.
- Output:
  - First-word-fall-through. m_axis_rx_tvalid = (fifo_level != 0) and m_axis_rx_tdata = mem[rd_ptr].
  - A word pushed at edge N is valid from cycle N+1.
  - On pop, rd_ptr increments modulo DEPTH.
  - Standard AXI-Stream rules apply: tdata is stable while tvalid && !tready.
- rx_fifo_data_ready:
  - Combinational from the registered fifo_level: (fifo_level >= max(burst_len,1)).
  - It is therefore guaranteed that a consumer seeing it high can drain burst_len words without an underflow stall.
- enable low:
  - The lane counter is forced to 0 and any partially packed word is discarded.
  - FIFO contents are retained and remain drainable.
  - Capture resumes at lane 0 on the first valid sample after enable returns high.
- flush:
  - On the next edge, pointers, level, lane and overflow_count go to 0.
  - flush has priority over a simultaneous push or pop.
  - It does not require enable to be low.
- Simultaneous events:
  - Push and pop in the same cycle while full: the push is accepted, the level stays at DEPTH, and no overflow is flagged.
  - Push and pop in the same cycle while empty: impossible, since tvalid=0 means there is no pop; the level becomes 1.
- Pointer width: pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are derived from fifo_level only.

Test Plan:
- Pack order: enable=1, then samples 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles. Required: tdata=0x44444444_33333333_22222222_11111111, with tvalid=1 and fifo_level=1 on the cycle after the 4th sample.
- Burst threshold: burst_len=16, tready=0, 64 samples fed. Required: rx_fifo_data_ready=0 at level 15 and 1 on the cycle level reaches 16. Then drain 1 word: ready drops to 0.
- Overflow: DEPTH=512, tready=0, 2056 samples fed (514 words). Required: level=512, overflow_count=2, two single-cycle overflow_ins pulses; the 512 stored words match samples 0..2047 in order.
- Full with simultaneous pop: FIFO full, tready=1 on the cycle the 4th lane-sample arrives. Required: level stays 512, overflow_count unchanged, and the new word appears as the last word after draining.
- Partial-word discard: 2 samples fed, enable=0 for 3 cycles, enable=1, then 4 samples A..D. Required: exactly one word, {D,C,B,A}, and level=1.
- Async reset mid-burst: FIFO at level 20 with tready=1, areset pulsed between clock edges. Required: tvalid, rx_fifo_data_ready and fifo_level are 0 before the next edge; after release, normal packing resumes at lane 0.

Source files
------------

// File: rtl/rx_sample_packer.sv
// rx_sample_packer: packs four 32-bit I/Q ADC samples into one 128-bit word
// and buffers the words in a first-word-fall-through FIFO. The FIFO is read
// out as an AXI-Stream master. The ADC side cannot be stalled, so any word
// that finds the FIFO full is dropped and counted.
module rx_sample_packer #(
  parameter  int DEPTH = 512,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             enable,
  input  logic             flush,
  input  logic [31:0]      s_adc_tdata,
  input  logic             s_adc_tvalid,
  input  logic [8:0]       burst_len,
  output logic [127:0]     m_axis_rx_tdata,
  output logic             m_axis_rx_tvalid,
  input  logic             m_axis_rx_tready,
  output logic             rx_fifo_data_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow_ins,
  output logic [15:0]      overflow_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Packer state: lane index plus the three lower samples of the word in progress
  logic [1:0]       lane_q, lane_d;
  logic [95:0]      pack_q, pack_d;

  // FIFO bookkeeping; full/empty come from the level alone, pointers just wrap
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Drop reporting
  logic             ovf_ins_q, ovf_ins_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;

  logic [127:0]     mem [DEPTH];

  logic             capture;
  logic             push;
  logic             pop;
  logic             pushOk;
  logic             pushDrop;
  logic [127:0]     pushWord;
  logic [8:0]       burstEff;

  // Handshake decode: a word completes on the lane-3 sample and may use a slot
  // freed by a pop on the same edge, so a full FIFO being drained never drops
  always_comb begin
    capture  = enable && s_adc_tvalid;
    push     = capture && (lane_q == 2'd3);
    pushWord = {s_adc_tdata, pack_q};
    pop      = m_axis_rx_tvalid && m_axis_rx_tready;
    pushOk   = push && ((level_q < LVL_W'(DEPTH)) || pop);
    pushDrop = push && !pushOk;
  end

  // Next-state logic; flush wins over any push or pop on the same edge,
  // and dropping enable throws away a partially packed word
  always_comb begin
    lane_d    = lane_q;
    pack_d    = pack_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_ins_d = 1'b0;
    ovf_cnt_d = ovf_cnt_q;

    if (flush) begin
      lane_d    = 2'd0;
      pack_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_cnt_d = '0;
    end else begin
      if (!enable) begin
        lane_d = 2'd0;
        pack_d = '0;
      end else if (capture) begin
        lane_d = lane_q + 2'd1;
        case (lane_q)
          2'd0:    pack_d[31:0]  = s_adc_tdata;
          2'd1:    pack_d[63:32] = s_adc_tdata;
          2'd2:    pack_d[95:64] = s_adc_tdata;
          default: pack_d        = '0;
        endcase
      end

      if (pushOk) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({pushOk, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      if (pushDrop) begin
        ovf_ins_d = 1'b1;
        if (ovf_cnt_q != 16'hFFFF) begin
          ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lane_q    <= 2'd0;
      pack_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_ins_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_ins_q <= ovf_ins_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage array; no reset needed because nothing reads a slot before it is written
  always_ff @(posedge aclk) begin
    if (pushOk && !flush) begin
      mem[wr_ptr_q] <= pushWord;
    end
  end

  // Output decode; tdata is gated by tvalid so it reads zero whenever the
  // FIFO is empty, including straight out of reset
  always_comb begin
    burstEff           = (burst_len == 9'd0) ? 9'd1 : burst_len;
    m_axis_rx_tvalid   = (level_q != '0);
    m_axis_rx_tdata    = m_axis_rx_tvalid ? mem[rd_ptr_q] : '0;
    rx_fifo_data_ready = (32'(level_q) >= 32'(burstEff));
    fifo_level         = level_q;
    overflow_ins       = ovf_ins_q;
    overflow_count     = ovf_cnt_q;
  end

endmodule

// File: tb/tb_rx_sample_packer.sv
// Testbench for rx_sample_packer: random ADC samples are fed through a
// queue-based reference model; expected words go into a scoreboard that a
// monitor drains on every AXI-Stream handshake.
module tb_rx_sample_packer;

  localparam int DEPTH = 512;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             aclk;
  logic             areset;
  logic             enable;
  logic             flush;
  logic [31:0]      s_adc_tdata;
  logic             s_adc_tvalid;
  logic [8:0]       burst_len;
  logic [127:0]     m_axis_rx_tdata;
  logic             m_axis_rx_tvalid;
  logic             m_axis_rx_tready;
  logic             rx_fifo_data_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow_ins;
  logic [15:0]      overflow_count;

  // Reference model state
  logic [31:0]  lanes [$];
  logic [127:0] sb [$];
  int           modelCount;
  int           modelOvf;
  int           modelDrops;
  int           ovfPulses;
  int           vectors;
  int           miscompares;

  rx_sample_packer #(.DEPTH(DEPTH)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .enable             (enable),
    .flush              (flush),
    .s_adc_tdata        (s_adc_tdata),
    .s_adc_tvalid       (s_adc_tvalid),
    .burst_len          (burst_len),
    .m_axis_rx_tdata    (m_axis_rx_tdata),
    .m_axis_rx_tvalid   (m_axis_rx_tvalid),
    .m_axis_rx_tready   (m_axis_rx_tready),
    .rx_fifo_data_ready (rx_fifo_data_ready),
    .fifo_level         (fifo_level),
    .overflow_ins       (overflow_ins),
    .overflow_count     (overflow_count)
  );

  // Free-running 100 MHz clock
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Global time limit so the bench always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, reports on mismatch
  function automatic void checkOutput(input string name, input logic [127:0] act,
                                      input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: every handshake pops one expected word; also counts overflow pulses
  always @(negedge aclk) begin
    if (!areset && !flush) begin
      if (m_axis_rx_tvalid && m_axis_rx_tready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL pop_unexpected: actual=%0h required=no word", m_axis_rx_tdata);
        end else begin
          checkOutput("pop_data", m_axis_rx_tdata, sb.pop_front());
        end
      end
      if (overflow_ins) ovfPulses++;
    end
  end

  // Drive one cycle of inputs, advance the model over the coming edge, and
  // return #1 after that edge
  task automatic applyStimulus(input bit en, input bit valid, input logic [31:0] data,
                               input bit ready, input bit fl);
    bit popNow;
    logic [127:0] word;
    enable           = en;
    s_adc_tvalid     = valid;
    s_adc_tdata      = data;
    m_axis_rx_tready = ready;
    flush            = fl;
    popNow = (modelCount > 0) && ready;
    if (fl) begin
      lanes.delete();
      sb.delete();
      modelCount = 0;
      modelOvf   = 0;
    end else begin
      if (!en) begin
        lanes.delete();
      end else if (valid) begin
        lanes.push_back(data);
        if (lanes.size() == 4) begin
          word = {lanes[3], lanes[2], lanes[1], lanes[0]};
          lanes.delete();
          if (modelCount < DEPTH || popNow) begin
            sb.push_back(word);
            modelCount++;
          end else begin
            modelDrops++;
            if (modelOvf < 16'hFFFF) modelOvf++;
          end
        end
      end
      if (popNow) modelCount--;
    end
    @(posedge aclk);
    #1;
  endtask

  // Pop everything out with tready held high, bounded by a cycle budget
  task automatic drainAll();
    for (int i = 0; i < DEPTH + 8 && modelCount > 0; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain_empty", 128'(fifo_level), 128'd0);
  endtask

  // Main stimulus sequence
  initial begin
    logic [31:0] smp [4];
    vectors = 0; miscompares = 0;
    modelCount = 0; modelOvf = 0; modelDrops = 0; ovfPulses = 0;
    enable = 1'b0; flush = 1'b0; s_adc_tdata = '0; s_adc_tvalid = 1'b0;
    burst_len = 9'd16; m_axis_rx_tready = 1'b0;
    areset = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_tvalid", 128'(m_axis_rx_tvalid), 128'd0);
    checkOutput("rst_tdata", m_axis_rx_tdata, 128'd0);
    checkOutput("rst_level", 128'(fifo_level), 128'd0);
    checkOutput("rst_ready", 128'(rx_fifo_data_ready), 128'd0);
    checkOutput("rst_ovf_ins", 128'(overflow_ins), 128'd0);
    checkOutput("rst_ovf_cnt", 128'(overflow_count), 128'd0);
    @(posedge aclk); @(posedge aclk); #1;
    areset = 1'b0;

    // Pack order
    applyStimulus(1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h33333333, 1'b0, 1'b0);
    checkOutput("pack_tvalid_before", 128'(m_axis_rx_tvalid), 128'd0);
    applyStimulus(1'b1, 1'b1, 32'h44444444, 1'b0, 1'b0);
    checkOutput("pack_tdata", m_axis_rx_tdata, 128'h44444444_33333333_22222222_11111111);
    checkOutput("pack_tvalid", 128'(m_axis_rx_tvalid), 128'd1);
    checkOutput("pack_level", 128'(fifo_level), 128'd1);
    drainAll();

    // Burst threshold at 16 words
    burst_len = 9'd16;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      checkOutput("burst_level", 128'(fifo_level), 128'(modelCount));
      checkOutput("burst_ready", 128'(rx_fifo_data_ready), 128'(modelCount >= 16));
    end
    checkOutput("burst_ready_at16", 128'(rx_fifo_data_ready), 128'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("burst_level_15", 128'(fifo_level), 128'd15);
    checkOutput("burst_ready_drop", 128'(rx_fifo_data_ready), 128'd0);
    drainAll();

    // burst_len of zero behaves as one
    burst_len = 9'd0;
    checkOutput("bl0_ready_empty", 128'(rx_fifo_data_ready), 128'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    checkOutput("bl0_ready_one", 128'(rx_fifo_data_ready), 128'd1);
    drainAll();
    burst_len = 9'd16;

    // Overflow: 514 words into a 512-word FIFO
    for (int i = 0; i < 2056; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_level", 128'(fifo_level), 128'd512);
    checkOutput("ovf_count", 128'(overflow_count), 128'd2);
    checkOutput("ovf_pulses", 128'(ovfPulses), 128'(modelDrops));
    checkOutput("ovf_ins_idle", 128'(overflow_ins), 128'd0);

    // Full with a simultaneous pop on the completing sample
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    checkOutput("fullpop_level", 128'(fifo_level), 128'd512);
    checkOutput("fullpop_ovf_count", 128'(overflow_count), 128'd2);
    checkOutput("fullpop_ovf_ins", 128'(overflow_ins), 128'd0);
    drainAll();

    // Partial word discarded when enable drops
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      smp[i] = $urandom;
      applyStimulus(1'b1, 1'b1, smp[i], 1'b0, 1'b0);
    end
    checkOutput("partial_level", 128'(fifo_level), 128'd1);
    checkOutput("partial_tdata", m_axis_rx_tdata, {smp[3], smp[2], smp[1], smp[0]});
    drainAll();

    // Flush clears words, lane and the overflow counter
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    checkOutput("flush_level", 128'(fifo_level), 128'd0);
    checkOutput("flush_ovf_count", 128'(overflow_count), 128'd0);
    checkOutput("flush_tvalid", 128'(m_axis_rx_tvalid), 128'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    checkOutput("flush_resume_level", 128'(fifo_level), 128'd1);
    drainAll();

    // Asynchronous reset mid-burst with a partial word pending
    for (int i = 0; i < 82; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    checkOutput("arst_level_pre", 128'(fifo_level), 128'd20);
    m_axis_rx_tready = 1'b1;
    s_adc_tvalid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    checkOutput("arst_tvalid", 128'(m_axis_rx_tvalid), 128'd0);
    checkOutput("arst_ready", 128'(rx_fifo_data_ready), 128'd0);
    checkOutput("arst_level", 128'(fifo_level), 128'd0);
    lanes.delete(); sb.delete(); modelCount = 0; modelOvf = 0;
    #2;
    areset = 1'b0;
    m_axis_rx_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp[i] = $urandom;
      applyStimulus(1'b1, 1'b1, smp[i], 1'b0, 1'b0);
    end
    checkOutput("arst_resume_level", 128'(fifo_level), 128'd1);
    checkOutput("arst_resume_tdata", m_axis_rx_tdata, {smp[3], smp[2], smp[1], smp[0]});
    drainAll();
    checkOutput("sb_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
